// File: rtl/uart_json_rx.sv
// UART receiver (8N1) feeding a fixed-format JSON motor command parser.
// Accepted frame: {"T":d,"L":[-]0.d,"R":[-]0.d}\n
// Outputs change only on a complete, well-formed frame.
module uart_json_rx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_in,
  output logic [3:0] cmd_type,
  output logic [3:0] left_speed,
  output logic       left_neg,
  output logic [3:0] right_speed,
  output logic       right_neg,
  output logic       cmd_valid,
  output logic       frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  localparam logic [7:0] CH_QUOTE  = 8'h22;
  localparam logic [7:0] CH_COMMA  = 8'h2C;
  localparam logic [7:0] CH_MINUS  = 8'h2D;
  localparam logic [7:0] CH_DOT    = 8'h2E;
  localparam logic [7:0] CH_ZERO   = 8'h30;
  localparam logic [7:0] CH_COLON  = 8'h3A;
  localparam logic [7:0] CH_L      = 8'h4C;
  localparam logic [7:0] CH_R      = 8'h52;
  localparam logic [7:0] CH_T      = 8'h54;
  localparam logic [7:0] CH_LBRACE = 8'h7B;
  localparam logic [7:0] CH_RBRACE = 8'h7D;
  localparam logic [7:0] CH_LF     = 8'h0A;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

  typedef enum logic [3:0] {
    WAIT_OPEN, T_HDR, T_DIG, L_HDR, L_SIGN, L_DOT, L_FRAC,
    R_HDR, R_SIGN, R_DOT, R_FRAC, CLOSE, EOL
  } p_state_t;

  // ASCII '0'..'9'
  function automatic logic is_digit(input logic [7:0] b);
    return (b >= 8'h30) && (b <= 8'h39);
  endfunction

  // Header literal character: "T": has no leading comma, ,"L": and ,"R": do
  function automatic logic [7:0] hdr_char(input logic [7:0] letter,
                                          input logic comma,
                                          input logic [2:0] idx);
    logic [2:0] k;
    k = comma ? idx : idx + 3'd1;
    case (k)
      3'd0:    return CH_COMMA;
      3'd1:    return CH_QUOTE;
      3'd2:    return letter;
      3'd3:    return CH_QUOTE;
      default: return CH_COLON;
    endcase
  endfunction

  logic          sync_a, rx_bit;
  rx_state_t     rx_state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    rx_shift;
  logic          break_wait;
  logic          byte_stb, line_err;

  p_state_t      p_state;
  logic [2:0]    lit_idx;
  logic          pend_neg;
  logic [3:0]    sh_type, sh_left, sh_right;
  logic          sh_lneg, sh_rneg;
  logic          byte_ok;

  // Two-flop synchronizer for the asynchronous serial line (idle high)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_a <= 1'b1;
      rx_bit <= 1'b1;
    end else begin
      sync_a <= uart_in;
      rx_bit <= sync_a;
    end
  end

  // Bit-level receiver: mid-bit sampling, byte strobe or framing error per byte
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state   <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      rx_shift   <= '0;
      break_wait <= 1'b0;
      byte_stb   <= 1'b0;
      line_err   <= 1'b0;
    end else begin
      byte_stb <= 1'b0;
      line_err <= 1'b0;
      case (rx_state)
        IDLE: begin
          cnt     <= '0;
          bit_idx <= '0;
          // after a bad stop bit the line must return high before re-arming
          if (rx_bit) break_wait <= 1'b0;
          else if (!break_wait) rx_state <= START;
        end
        START: begin
          if (cnt == HALF_LAST) begin
            cnt      <= '0;
            rx_state <= rx_bit ? IDLE : DATA;
          end else cnt <= cnt + 1'b1;
        end
        DATA: begin
          if (cnt == FULL_LAST) begin
            cnt      <= '0;
            rx_shift <= {rx_bit, rx_shift[7:1]};
            bit_idx  <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) rx_state <= STOP;
          end else cnt <= cnt + 1'b1;
        end
        STOP: begin
          if (cnt == FULL_LAST) begin
            cnt      <= '0;
            rx_state <= IDLE;
            if (rx_bit) byte_stb <= 1'b1;
            else begin
              line_err   <= 1'b1;
              break_wait <= 1'b1;
            end
          end else cnt <= cnt + 1'b1;
        end
        default: rx_state <= IDLE;
      endcase
    end
  end

  // Decide whether the received byte is acceptable in the current parser state
  always_comb begin
    byte_ok = 1'b0;
    case (p_state)
      WAIT_OPEN:              byte_ok = 1'b1;
      T_HDR:                  byte_ok = (rx_shift == hdr_char(CH_T, 1'b0, lit_idx));
      L_HDR:                  byte_ok = (rx_shift == hdr_char(CH_L, 1'b1, lit_idx));
      R_HDR:                  byte_ok = (rx_shift == hdr_char(CH_R, 1'b1, lit_idx));
      T_DIG, L_FRAC, R_FRAC:  byte_ok = is_digit(rx_shift);
      L_SIGN, R_SIGN:         byte_ok = (rx_shift == CH_ZERO) ||
                                        ((rx_shift == CH_MINUS) && !pend_neg);
      L_DOT, R_DOT:           byte_ok = (rx_shift == CH_DOT);
      CLOSE:                  byte_ok = (rx_shift == CH_RBRACE);
      EOL:                    byte_ok = (rx_shift == CH_LF);
      default:                byte_ok = 1'b0;
    endcase
  end

  // Frame parser: shadow capture, commit on newline, abort/resync on errors
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_state     <= WAIT_OPEN;
      lit_idx     <= '0;
      pend_neg    <= 1'b0;
      sh_type     <= '0;
      sh_left     <= '0;
      sh_right    <= '0;
      sh_lneg     <= 1'b0;
      sh_rneg     <= 1'b0;
      cmd_type    <= '0;
      left_speed  <= '0;
      left_neg    <= 1'b0;
      right_speed <= '0;
      right_neg   <= 1'b0;
      cmd_valid   <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      cmd_valid <= 1'b0;
      frame_err <= 1'b0;
      if (line_err || (byte_stb && !byte_ok)) begin
        frame_err <= 1'b1;
        lit_idx   <= '0;
        pend_neg  <= 1'b0;
        sh_type   <= '0;
        sh_left   <= '0;
        sh_right  <= '0;
        sh_lneg   <= 1'b0;
        sh_rneg   <= 1'b0;
        // a stray '{' is taken as the start of a fresh frame
        p_state   <= (byte_stb && rx_shift == CH_LBRACE) ? T_HDR : WAIT_OPEN;
      end else if (byte_stb) begin
        case (p_state)
          WAIT_OPEN: if (rx_shift == CH_LBRACE) begin
            p_state <= T_HDR;
            lit_idx <= '0;
          end
          T_HDR: if (lit_idx == 3'd3) begin
            lit_idx <= '0;
            p_state <= T_DIG;
          end else lit_idx <= lit_idx + 3'd1;
          T_DIG: begin
            sh_type <= rx_shift[3:0];
            p_state <= L_HDR;
          end
          L_HDR: if (lit_idx == 3'd4) begin
            lit_idx <= '0;
            p_state <= L_SIGN;
          end else lit_idx <= lit_idx + 3'd1;
          L_SIGN: if (rx_shift == CH_MINUS) pend_neg <= 1'b1;
                  else p_state <= L_DOT;
          L_DOT:  p_state <= L_FRAC;
          L_FRAC: begin
            sh_left  <= rx_shift[3:0];
            sh_lneg  <= pend_neg && (rx_shift != CH_ZERO);
            pend_neg <= 1'b0;
            p_state  <= R_HDR;
          end
          R_HDR: if (lit_idx == 3'd4) begin
            lit_idx <= '0;
            p_state <= R_SIGN;
          end else lit_idx <= lit_idx + 3'd1;
          R_SIGN: if (rx_shift == CH_MINUS) pend_neg <= 1'b1;
                  else p_state <= R_DOT;
          R_DOT:  p_state <= R_FRAC;
          R_FRAC: begin
            sh_right <= rx_shift[3:0];
            sh_rneg  <= pend_neg && (rx_shift != CH_ZERO);
            pend_neg <= 1'b0;
            p_state  <= CLOSE;
          end
          CLOSE:  p_state <= EOL;
          EOL: begin
            cmd_type    <= sh_type;
            left_speed  <= sh_left;
            left_neg    <= sh_lneg;
            right_speed <= sh_right;
            right_neg   <= sh_rneg;
            cmd_valid   <= 1'b1;
            p_state     <= WAIT_OPEN;
          end
          default: p_state <= WAIT_OPEN;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_json_rx.sv
// Scoreboard bench for uart_json_rx: directed frames with hand-computed results.
`timescale 1ns/1ps
module tb_uart_json_rx;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       uart_in;
  logic [3:0] cmd_type, left_speed, right_speed;
  logic       left_neg, right_neg, cmd_valid, frame_err;

  typedef struct packed {
    logic       is_err;
    logic [3:0] t;
    logic [3:0] l;
    logic       ln;
    logic [3:0] r;
    logic       rn;
  } ev_t;

  ev_t exp_q[$];
  int  total = 0;
  int  bad = 0;
  int  n_cmd = 0, n_err = 0;
  int  exp_cmd = 0, exp_err = 0;
  logic [3:0] cur_t = 0, cur_l = 0, cur_r = 0;
  logic       cur_ln = 0, cur_rn = 0;

  uart_json_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst_n(rst_n), .uart_in(uart_in),
    .cmd_type(cmd_type), .left_speed(left_speed), .left_neg(left_neg),
    .right_speed(right_speed), .right_neg(right_neg),
    .cmd_valid(cmd_valid), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  initial begin
    #900us;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  task automatic expect_cmd(input logic [3:0] t, input logic [3:0] l, input logic ln,
                            input logic [3:0] r, input logic rn);
    exp_q.push_back('{1'b0, t, l, ln, r, rn});
    cur_t = t; cur_l = l; cur_ln = ln; cur_r = r; cur_rn = rn;
    exp_cmd++;
  endtask

  task automatic expect_err();
    exp_q.push_back('{1'b1, cur_t, cur_l, cur_ln, cur_r, cur_rn});
    exp_err++;
  endtask

  task automatic monitor();
    ev_t e;
    logic ok;
    forever begin
      @(negedge clk);
      if (rst_n && (cmd_valid || frame_err)) begin
        if (cmd_valid) n_cmd++;
        if (frame_err) n_err++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_event: got cmd_valid=%0b frame_err=%0b, want no event",
                   cmd_valid, frame_err);
        end else begin
          e = exp_q.pop_front();
          ok = (cmd_valid == !e.is_err) && (frame_err == e.is_err) &&
               (cmd_type == e.t) && (left_speed == e.l) && (left_neg == e.ln) &&
               (right_speed == e.r) && (right_neg == e.rn);
          if (!ok) begin
            bad++;
            $display("FAIL %s: got v=%0b e=%0b t=%0d l=%0d ln=%0b r=%0d rn=%0b, want v=%0b e=%0b t=%0d l=%0d ln=%0b r=%0d rn=%0b",
                     e.is_err ? "err_event" : "cmd_event", cmd_valid, frame_err,
                     cmd_type, left_speed, left_neg, right_speed, right_neg,
                     !e.is_err, e.is_err, e.t, e.l, e.ln, e.r, e.rn);
          end
        end
      end
    end
  endtask

  task automatic idle_bits(input int n);
    uart_in = 1'b1;
    repeat (n * CPB) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_stop);
    uart_in = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_in = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_in = !bad_stop;
    repeat (CPB) @(negedge clk);
    uart_in = 1'b1;
    if (bad_stop) repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b0);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 40 * CPB) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s: got %0d pending events, want 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_zero(input string name);
    total++;
    if ({cmd_type, left_speed, left_neg, right_speed, right_neg, cmd_valid, frame_err} != 15'd0) begin
      bad++;
      $display("FAIL %s: got t=%0d l=%0d ln=%0b r=%0d rn=%0b v=%0b e=%0b, want all 0",
               name, cmd_type, left_speed, left_neg, right_speed, right_neg, cmd_valid, frame_err);
    end
  endtask

  initial begin
    logic [7:0] rb;
    rst_n   = 1'b0;
    uart_in = 1'b1;
    repeat (5) @(negedge clk);
    check_zero("reset_state");
    rst_n = 1'b1;
    fork monitor(); join_none
    idle_bits(2);

    // basic frame
    expect_cmd(4'd1, 4'd5, 1'b0, 4'd5, 1'b0);
    send_str("{\"T\":1,\"L\":0.5,\"R\":0.5}\n");
    wait_drain("drain_basic");

    // signs on each wheel
    expect_cmd(4'd1, 4'd3, 1'b1, 4'd3, 1'b0);
    send_str("{\"T\":1,\"L\":-0.3,\"R\":0.3}\n");
    expect_cmd(4'd1, 4'd7, 1'b0, 4'd7, 1'b1);
    send_str("{\"T\":1,\"L\":0.7,\"R\":-0.7}\n");
    wait_drain("drain_signs");

    // line glitch shorter than half a bit is ignored
    uart_in = 1'b0;
    repeat (3) @(negedge clk);
    idle_bits(3);

    // parse error at 'X', then a good frame
    expect_err();
    expect_cmd(4'd1, 4'd0, 1'b0, 4'd2, 1'b0);
    send_str("{\"T\":1,\"L\":0.5,\"X\"");
    send_str("{\"T\":1,\"L\":0.0,\"R\":0.2}\n");
    wait_drain("drain_parse_err");

    // bad stop bit on the 'L' byte aborts the frame
    expect_err();
    send_str("{\"T\":2,\"");
    send_byte(8'h4C, 1'b1);
    send_str("\":0.1,\"R\":0.9}\n");
    expect_cmd(4'd3, 4'd8, 1'b1, 4'd6, 1'b0);
    send_str("{\"T\":3,\"L\":-0.8,\"R\":0.6}\n");
    wait_drain("drain_stop_err");

    // double minus rejected; -0.0 reports positive
    expect_err();
    send_str("{\"T\":1,\"L\":-0.0,\"R\":--0.4}\n");
    expect_cmd(4'd4, 4'd0, 1'b0, 4'd4, 1'b1);
    send_str("{\"T\":4,\"L\":-0.0,\"R\":-0.4}\n");
    wait_drain("drain_neg_zero");

    // '{' mid-frame: error and immediate resync
    expect_err();
    expect_cmd(4'd6, 4'd2, 1'b0, 4'd3, 1'b0);
    send_str("{\"T\":5,\"L\":0.1{\"T\":6,\"L\":0.2,\"R\":0.3}\n");
    wait_drain("drain_resync");

    // noise between frames is ignored
    expect_cmd(4'd9, 4'd9, 1'b0, 4'd1, 1'b1);
    send_str("\r  x");
    send_str("{\"T\":9,\"L\":0.9,\"R\":-0.1}\n");
    wait_drain("drain_noise");

    // reset during the 'R' byte
    send_str("{\"T\":7,\"L\":0.5,\"");
    rb = 8'h52;
    uart_in = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      uart_in = rb[i];
      repeat (CPB) @(negedge clk);
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset_mid_frame");
    uart_in = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    cur_t = 0; cur_l = 0; cur_ln = 0; cur_r = 0; cur_rn = 0;
    idle_bits(4);
    expect_cmd(4'd8, 4'd4, 1'b0, 4'd5, 1'b1);
    send_str("{\"T\":8,\"L\":0.4,\"R\":-0.5}\n");
    wait_drain("drain_after_reset");
    idle_bits(4);

    total++;
    if (n_cmd != exp_cmd) begin
      bad++;
      $display("FAIL cmd_count: got %0d, want %0d", n_cmd, exp_cmd);
    end
    total++;
    if (n_err != exp_err) begin
      bad++;
      $display("FAIL err_count: got %0d, want %0d", n_err, exp_err);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_json_rx.md
UART_JSON_RX -- requirements
Module: uart_json_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434 (50_000_000/115_200), clocks per UART bit.
REQ-002 clk  input  1  system clock, 50 MHz; one clock domain.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 uart_in  input  1  serial line, 8N1, LSB first, idle high.
REQ-005 cmd_type  output  4  binary value of the "T" digit.
REQ-006 left_speed  output  4  left fractional digit, 0-9 (tenths).
REQ-007 left_neg  output  1  left wheel reverse.
REQ-008 right_speed  output  4  right fractional digit, 0-9.
REQ-009 right_neg  output  1  right wheel reverse.
REQ-010 cmd_valid  output  1  one-cycle pulse when outputs are updated.
REQ-011 frame_err  output  1  one-cycle pulse on a line framing error or a parse error.

Function
REQ-012 uart_in SHALL pass through a 2-FF synchronizer; all RX logic SHALL use the synchronized bit.
REQ-013 RX FSM states: IDLE, START, DATA, STOP.
- IDLE -> START on a synchronized low.
- START: sample at CLKS_PER_BIT/2; low -> DATA, high -> IDLE (glitch, no error).
- DATA: sample 8 bits at CLKS_PER_BIT intervals, LSB first.
- STOP: sample after CLKS_PER_BIT; high -> byte strobe for 1 cycle; low -> frame_err pulse, no strobe.
- Return to IDLE after STOP.
REQ-014 After a low stop bit, RX SHALL wait for the line to be high before re-arming, so a break is not read as bytes.
REQ-015 Parser SHALL advance only on a byte strobe and SHALL accept exactly: {"T":d,"L":[-]0.d,"R":[-]0.d}\n, where d is an ASCII '0'-'9'.
REQ-016 Parser states: WAIT_OPEN, T_HDR, T_DIG, L_HDR, L_SIGN, L_DOT, L_FRAC, R_HDR, R_SIGN, R_DOT, R_FRAC, CLOSE, EOL.
- T_HDR, L_HDR and R_HDR match fixed literals with a 3-bit literal index.
- T_HDR matches "T":. L_HDR matches ,"L":. R_HDR matches ,"R":.
REQ-017 L_SIGN/R_SIGN:
- '-' sets the pending neg flag and stays in the state, once only.
- '0' advances to the DOT state.
- Any other byte, or a second '-', is an error.
REQ-018 Captured digits SHALL be held in shadow registers (byte - 8'h30, 4 bits). Outputs SHALL NOT change until EOL receives 8'h0A.
REQ-019 On '\n' in EOL, the next cycle SHALL:
- copy the shadow registers to the outputs;
- pulse cmd_valid;
- return to WAIT_OPEN.
Latency is 1 clk after the '\n' byte strobe.
REQ-020 A zero speed with a '-' sign SHALL output neg=0.
REQ-021 Any mismatched byte SHALL:
- pulse frame_err;
- clear the shadow registers;
- go to WAIT_OPEN, except when the byte is '{', which goes directly to T_HDR (resync).
REQ-022 In WAIT_OPEN, non-'{' bytes (e.g. CR, spaces) SHALL be ignored silently.
REQ-023 An RX framing error mid-frame SHALL abort the parse to WAIT_OPEN. frame_err SHALL pulse once, not twice.
REQ-024 Outputs SHALL keep their last valid values indefinitely. Bad frames SHALL never alter them.

Reset
REQ-025 While rst_n=0:
- RX goes to IDLE and the parser to WAIT_OPEN.
- Literal index and shadow registers are 0.
- cmd_type=0, left_speed=0, right_speed=0, left_neg=0, right_neg=0, cmd_valid=0, frame_err=0.
REQ-026 Reset asserted mid-byte or mid-frame SHALL discard the partial data. After release, the first complete valid frame SHALL be decoded normally.

Verification
REQ-027 Send {"T":1,"L":0.5,"R":0.5}\n at 115200 baud.
- Response: one cmd_valid, 1 clk after the '\n' strobe.
- Outputs: cmd_type=1, left_speed=5, right_speed=5, both neg=0.
REQ-028 Send {"T":1,"L":-0.3,"R":0.3}\n, then {"T":1,"L":0.7,"R":-0.7}\n.
- First frame: left_neg=1/left_speed=3, right_neg=0/right_speed=3.
- Second frame: left_neg=0/left_speed=7, right_neg=1/right_speed=7.
REQ-029 Send {"T":1,"L":0.5,"X" followed by {"T":1,"L":0.0,"R":0.2}\n.
- Response: one frame_err at 'X', then resync on '{'.
- Outputs: left_speed=0, right_speed=2, cmd_valid once.
- The earlier output values are unchanged until that cmd_valid.
REQ-030 Corrupt the stop bit of the 'L' byte in a valid frame.
- Response: frame_err once, no cmd_valid, outputs unchanged.
- The following valid frame decodes correctly.
REQ-031 Send {"T":1,"L":-0.0,"R":--0.4}\n.
- Response: frame_err at the second '-' in R_SIGN, no update.
- Separately, a frame with "L":-0.0 yields left_neg=0.
REQ-032 Pull rst_n low during the 'R' byte, release, then send a valid frame.
- During reset: all outputs 0.
- After release: no spurious cmd_valid; the next frame decodes correctly.
